hazard_detection_unit: RTL and testbench

The forwarding path cannot resolve some pipeline hazards. This block resolves those by stalling, bubbling and flushing the 5-stage pipeline. It covers three cases: load-use hazards in ID, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses in MEM. It sits in the core top level beside the forwarding unit and drives the write-enable and flush controls of the PC and pipeline registers. It also provides stall and flush performance counters.

---
 rtl/hazard_detection_unit.sv | 95 +++++++++
 tb/tb_hazard_detection_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - pipeline stall/bubble/flush control for load-use, taken branches and multi-cycle memory
// Outputs are combinational from the RUN/WAIT state and current inputs; perf counters track stalls and flushes.
module hazard_detection_unit #(
   parameter int MEM_LATENCY = 1,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pipe_freeze,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int CW = $clog2(MEM_LATENCY) + 1;
   localparam bit MULTI_CYCLE = (MEM_LATENCY > 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

   typedef enum logic {ST_RUN, ST_WAIT} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          load_use;
   logic          freeze_start;
   logic          freeze_hold;

   always_comb begin
      load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                 ((id_uses_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                  (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));
      // In the release cycle the same access is still in MEM, so mem_access is not re-armed.
      freeze_start = (state == ST_RUN) && mem_access && MULTI_CYCLE;
      freeze_hold  = (state == ST_WAIT) && (wait_cnt != '0);
   end

   always_comb begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_freeze = 1'b0;
      if (rst_n) begin
         if (freeze_start || freeze_hold) begin
            pipe_freeze = 1'b1;
         end else if (ex_branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            id_ex_flush = 1'b1;
         end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RUN;
         wait_cnt     <= '0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (freeze_start) begin
                  state    <= ST_WAIT;
                  wait_cnt <= LOAD_VAL;
               end
            end
            ST_WAIT: begin
               if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
               else                state    <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
         if (!pc_write)   stall_cycles <= stall_cycles + CNT_W'(1);
         if (if_id_flush) flush_count  <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - directed bench for hazard_detection_unit at MEM_LATENCY 4 and 1
// Control vectors are packed {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}.
module tb_hazard_detection_unit;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs1, rs2, ex_rd;
   logic       uses1, uses2, mem_read, br, mem_acc;

   logic        pcw4, ifw4, iff4, ief4, frz4;
   logic        pcw1, ifw1, iff1, ief1, frz1;
   logic [31:0] stall4, flush4, stall1, flush1;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] es4 = 0, ef4 = 0, es1 = 0, ef1 = 0;
   logic [4:0]  e4, e1;

   wire [4:0] ctl4 = {pcw4, ifw4, iff4, ief4, frz4};
   wire [4:0] ctl1 = {pcw1, ifw1, iff1, ief1, frz1};

   hazard_detection_unit #(.MEM_LATENCY(4), .CNT_W(32)) u_lat4 (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_uses_rs1(uses1), .id_uses_rs2(uses2),
      .ex_rd_addr(ex_rd), .ex_mem_read(mem_read), .ex_branch_taken(br), .mem_access(mem_acc),
      .pc_write(pcw4), .if_id_write(ifw4), .if_id_flush(iff4), .id_ex_flush(ief4),
      .pipe_freeze(frz4), .stall_cycles(stall4), .flush_count(flush4)
   );

   hazard_detection_unit #(.MEM_LATENCY(1), .CNT_W(32)) u_lat1 (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_uses_rs1(uses1), .id_uses_rs2(uses2),
      .ex_rd_addr(ex_rd), .ex_mem_read(mem_read), .ex_branch_taken(br), .mem_access(mem_acc),
      .pc_write(pcw1), .if_id_write(ifw1), .if_id_flush(iff1), .id_ex_flush(ief1),
      .pipe_freeze(frz1), .stall_cycles(stall1), .flush_count(flush1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
      uses1 = 1'b0; uses2 = 1'b0; mem_read = 1'b0; br = 1'b0; mem_acc = 1'b0;
   endtask

   // Advance one clock while tracking the expected counter values.
   task automatic tick(input logic [4:0] x4, input logic [4:0] x1);
      if (!x4[4]) es4 = es4 + 1;
      if (x4[2])  ef4 = ef4 + 1;
      if (!x1[4]) es1 = es1 + 1;
      if (x1[2])  ef1 = ef1 + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      set_idle();
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (ctl4 !== 5'b00000) begin n_err++; $display("FAIL reset_async_ctl4: got %b want 00000", ctl4); end
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (ctl1 !== 5'b00000) begin n_err++; $display("FAIL reset_ctl1: got %b want 00000", ctl1); end
      n_vec++; if (stall4 !== 32'd0) begin n_err++; $display("FAIL reset_stall4: got %0d want 0", stall4); end
      n_vec++; if (flush4 !== 32'd0) begin n_err++; $display("FAIL reset_flush4: got %0d want 0", flush4); end
      rst_n = 1'b1;
      #1;
      n_vec++; if (ctl4 !== 5'b11000) begin n_err++; $display("FAIL reset_release_ctl4: got %b want 11000", ctl4); end
      tick(5'b11000, 5'b11000);
   endtask

   task automatic test_load_use();
      mem_read = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; uses1 = 1'b1;
      #1;
      n_vec++; if (ctl4 !== 5'b00010) begin n_err++; $display("FAIL load_use_ctl4: got %b want 00010", ctl4); end
      n_vec++; if (ctl1 !== 5'b00010) begin n_err++; $display("FAIL load_use_ctl1: got %b want 00010", ctl1); end
      tick(5'b00010, 5'b00010);
      set_idle();
      #1;
      n_vec++; if (ctl4 !== 5'b11000) begin n_err++; $display("FAIL load_use_one_bubble: got %b want 11000", ctl4); end
      n_vec++; if (stall4 !== 32'd1) begin n_err++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall4); end
      tick(5'b11000, 5'b11000);
   endtask

   task automatic test_no_stall();
      logic [4:0] exp_tab [3];
      exp_tab[0] = 5'b11000; exp_tab[1] = 5'b11000; exp_tab[2] = 5'b00010;
      for (int i = 0; i < 3; i++) begin
         set_idle();
         mem_read = 1'b1; uses1 = 1'b1;
         case (i)
            0: begin ex_rd = 5'd0; rs1 = 5'd0; end
            1: begin ex_rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; uses2 = 1'b0; end
            default: begin ex_rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; uses2 = 1'b1; end
         endcase
         #1;
         n_vec++; if (ctl4 !== exp_tab[i]) begin n_err++; $display("FAIL no_stall_%0d: got %b want %b", i, ctl4, exp_tab[i]); end
         tick(exp_tab[i], exp_tab[i]);
      end
      set_idle();
   endtask

   task automatic test_branch();
      mem_read = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; uses1 = 1'b1; br = 1'b1;
      #1;
      n_vec++; if (ctl4 !== 5'b11110) begin n_err++; $display("FAIL branch_over_load_use: got %b want 11110", ctl4); end
      tick(5'b11110, 5'b11110);
      set_idle();
      #1;
      n_vec++; if (flush4 !== 32'd1) begin n_err++; $display("FAIL branch_flush_cnt: got %0d want 1", flush4); end
      n_vec++; if (stall4 !== es4) begin n_err++; $display("FAIL branch_stall_cnt: got %0d want %0d", stall4, es4); end
      tick(5'b11000, 5'b11000);
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 4; i++) begin
         set_idle();
         mem_acc = 1'b1;
         br = (i == 3);
         e4 = (i < 3) ? 5'b00001 : 5'b11110;
         e1 = (i < 3) ? 5'b11000 : 5'b11110;
         #1;
         n_vec++; if (ctl4 !== e4) begin n_err++; $display("FAIL mem_wait4_cyc%0d: got %b want %b", i, ctl4, e4); end
         n_vec++; if (ctl1 !== e1) begin n_err++; $display("FAIL mem_wait1_cyc%0d: got %b want %b", i, ctl1, e1); end
         tick(e4, e1);
      end
      set_idle();
      #1;
      n_vec++; if (ctl4 !== 5'b11000) begin n_err++; $display("FAIL mem_wait_after: got %b want 11000", ctl4); end
      n_vec++; if (stall4 !== es4) begin n_err++; $display("FAIL mem_wait_stall4: got %0d want %0d", stall4, es4); end
      n_vec++; if (flush4 !== ef4) begin n_err++; $display("FAIL mem_wait_flush4: got %0d want %0d", flush4, ef4); end
      n_vec++; if (stall1 !== es1) begin n_err++; $display("FAIL mem_wait_stall1: got %0d want %0d", stall1, es1); end
      tick(5'b11000, 5'b11000);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         set_idle();
         mem_acc = 1'b1;
         e4 = ((i % 4) == 3) ? 5'b11000 : 5'b00001;
         #1;
         n_vec++; if (ctl4 !== e4) begin n_err++; $display("FAIL b2b_lat4_cyc%0d: got %b want %b", i, ctl4, e4); end
         n_vec++; if (ctl1 !== 5'b11000) begin n_err++; $display("FAIL b2b_lat1_cyc%0d: got %b want 11000", i, ctl1); end
         tick(e4, 5'b11000);
      end
      set_idle();
      #1;
      n_vec++; if (stall4 !== es4) begin n_err++; $display("FAIL b2b_stall4: got %0d want %0d", stall4, es4); end
      n_vec++; if (stall1 !== es1) begin n_err++; $display("FAIL b2b_stall1: got %0d want %0d", stall1, es1); end
      tick(5'b11000, 5'b11000);
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 0; i < 2; i++) begin
         set_idle();
         mem_acc = 1'b1;
         #1;
         n_vec++; if (ctl4 !== 5'b00001) begin n_err++; $display("FAIL rmw_freeze_cyc%0d: got %b want 00001", i, ctl4); end
         if (i == 0) tick(5'b00001, 5'b11000);
      end
      rst_n = 1'b0;
      #1;
      n_vec++; if (ctl4 !== 5'b00000) begin n_err++; $display("FAIL rmw_async_drop: got %b want 00000", ctl4); end
      @(posedge clk);
      #1;
      es4 = 0; ef4 = 0; es1 = 0; ef1 = 0;
      set_idle();
      rst_n = 1'b1;
      #1;
      n_vec++; if (ctl4 !== 5'b11000) begin n_err++; $display("FAIL rmw_release: got %b want 11000", ctl4); end
      n_vec++; if (stall4 !== 32'd0) begin n_err++; $display("FAIL rmw_stall_cleared: got %0d want 0", stall4); end
      n_vec++; if (flush4 !== 32'd0) begin n_err++; $display("FAIL rmw_flush_cleared: got %0d want 0", flush4); end
      tick(5'b11000, 5'b11000);
      n_vec++; if (ctl4 !== 5'b11000) begin n_err++; $display("FAIL rmw_no_residual: got %b want 11000", ctl4); end
      tick(5'b11000, 5'b11000);
      for (int i = 0; i < 4; i++) begin
         mem_acc = (i == 0);
         e4 = (i < 3) ? 5'b00001 : 5'b11000;
         #1;
         n_vec++; if (ctl4 !== e4) begin n_err++; $display("FAIL rmw_new_access_cyc%0d: got %b want %b", i, ctl4, e4); end
         tick(e4, 5'b11000);
      end
      n_vec++; if (stall4 !== 32'd3) begin n_err++; $display("FAIL rmw_new_stall_cnt: got %0d want 3", stall4); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch();
      test_mem_wait();
      test_back_to_back();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
